// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector whose fallback transitions are derived
// from PATTERN at elaboration, with a one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit               OVERLAP = 1'b0,
   parameter int               CNT_W   = 8
) (
   input  logic                         clk_i,
   input  logic                         clr_i,
   input  logic                         valid_i,
   input  logic                         input_i,
   output logic                         match_o,
   output logic [CNT_W-1:0]             match_cnt_o,
   output logic [$clog2(PAT_W+1)-1:0]   state_o
);
   localparam int SW = $clog2(PAT_W+1);
   typedef logic [SW-1:0] state_t;
   // Longest proper prefix of PATTERN that ends the history "first k pattern bits, then b".
   function automatic state_t next_fn(input int k, input logic b);
      logic [PAT_W:0] s;
      logic ok;
      int best;
      s = (PAT_W+1)'(PATTERN) >> (PAT_W - k);
      s = {s[PAT_W-1:0], b};
      best = 0;
      for (int l = 1; l < PAT_W; l++) begin
         ok = (l <= k + 1);
         for (int i = 0; i < l; i++) ok &= (s[i] == PATTERN[PAT_W-l+i]);
         if (ok) best = l;
      end
      return (k == PAT_W - 1 && b == PATTERN[0] && !OVERLAP) ? '0 : state_t'(best);
   endfunction
   state_t nxt0 [2**SW];
   state_t nxt1 [2**SW];
   for (genvar k = 0; k < 2**SW; k++) begin : g_tbl
      if (k < PAT_W) begin : g_v
         assign nxt0[k] = next_fn(k, 1'b0);
         assign nxt1[k] = next_fn(k, 1'b1);
      end else begin : g_z
         assign nxt0[k] = '0;
         assign nxt1[k] = '0;
      end
   end
   state_t           state_q, state_d;
   logic             match_q, match_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      match_d = valid_i && state_q == state_t'(PAT_W - 1) && input_i == PATTERN[0];
      state_d = valid_i ? (input_i ? nxt1[state_q] : nxt0[state_q]) : state_q;
      cnt_d   = (match_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end
   assign match_o     = match_q;
   assign match_cnt_o = cnt_q;
   assign state_o     = state_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: four detector configurations share one random/directed bit stream;
// a history-based reference model feeds a scoreboard queue drained by a monitor.
module tb_seq_detector_param;
   logic clk = 1'b0;
   logic clr = 1'b1;
   logic valid = 1'b0;
   logic din = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       m0, m1, m2, m3;
   logic [7:0] c0, c1;
   logic [1:0] c2;
   logic [3:0] c3;
   logic [2:0] s0, s1, s2, s3;

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
      .clk_i(clk), .clr_i(clr), .valid_i(valid), .input_i(din),
      .match_o(m0), .match_cnt_o(c0), .state_o(s0));
   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
      .clk_i(clk), .clr_i(clr), .valid_i(valid), .input_i(din),
      .match_o(m1), .match_cnt_o(c1), .state_o(s1));
   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d2 (
      .clk_i(clk), .clr_i(clr), .valid_i(valid), .input_i(din),
      .match_o(m2), .match_cnt_o(c2), .state_o(s2));
   seq_detector_param #(.PAT_W(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(4)) d3 (
      .clk_i(clk), .clr_i(clr), .valid_i(valid), .input_i(din),
      .match_o(m3), .match_cnt_o(c3), .state_o(s3));

   int          pw  [4] = '{4, 4, 4, 6};
   logic [15:0] pat [4] = '{16'b1011, 16'b1011, 16'b1011, 16'b110110};
   bit          ovl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   int          cw  [4] = '{8, 8, 2, 4};

   typedef struct packed {
      logic [3:0]      m;
      logic [3:0][7:0] c;
      logic [3:0][2:0] s;
      int              due;
   } exp_t;
   exp_t q[$];

   logic [63:0] hist [4];
   int          hlen [4];
   int          cnt  [4];
   int          total = 0;
   int          passed = 0;

   function automatic bit ends_with(logic [63:0] h, int hl, logic [15:0] p, int w, int l);
      if (l > hl) return 1'b0;
      for (int i = 0; i < l; i++) if (h[i] != p[w-l+i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input bit c, input bit v, input bit b);
      exp_t e;
      int   st;
      @(posedge clk);
      #2;
      clr = c;
      valid = v;
      din = b;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            hist[i] = '0;
            hlen[i] = 0;
            cnt[i] = 0;
         end else if (v) begin
            hist[i] = {hist[i][62:0], b};
            hlen[i] = (hlen[i] < 64) ? hlen[i] + 1 : 64;
            e.m[i] = ends_with(hist[i], hlen[i], pat[i], pw[i], pw[i]);
            if (e.m[i]) begin
               if (cnt[i] < (1 << cw[i]) - 1) cnt[i]++;
               if (!ovl[i]) hlen[i] = 0;
            end
         end
         st = 0;
         for (int l = 1; l < pw[i]; l++) if (ends_with(hist[i], hlen[i], pat[i], pw[i], l)) st = l;
         e.c[i] = 8'(cnt[i]);
         e.s[i] = 3'(st);
      end
      e.due = cyc + 1;
      q.push_back(e);
   endtask

   task automatic bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i]);
   endtask

   task automatic chk(input string nm, input int i, input int act, input int ex);
      total++;
      if (act == ex) passed++;
      else $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, i, cyc, act, ex);
   endtask

   logic       act_m [4];
   logic [7:0] act_c [4];
   logic [2:0] act_s [4];
   assign act_m = '{m0, m1, m2, m3};
   assign act_c = '{c0, c1, {6'b0, c2}, {4'b0, c3}};
   assign act_s = '{s0, s1, s2, s3};

   exp_t mon_e;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         mon_e = q.pop_front();
         for (int i = 0; i < 4; i++) begin
            chk("match", i, int'(act_m[i]), int'(mon_e.m[i]));
            chk("count", i, int'(act_c[i]), int'(mon_e.c[i]));
            chk("state", i, int'(act_s[i]), int'(mon_e.s[i]));
         end
      end
   end

   initial begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      bits(32'b1011011, 7);
      step(1'b1, 1'b0, 1'b0);
      bits(32'b11011, 5);
      step(1'b1, 1'b0, 1'b0);
      bits(32'b10, 2);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      bits(32'b11, 2);
      step(1'b1, 1'b0, 1'b0);
      bits(32'b101, 3);
      step(1'b1, 1'b1, 1'b1);
      bits(32'b1, 1);
      step(1'b1, 1'b0, 1'b0);
      bits(32'b10111011101110111011, 20);
      bits(32'b110110110110110, 15);
      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 149) == 0, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
